// File: rtl/audio_avg_filter.sv
`default_nettype none
// ============================================================================
// Module   : audio_avg_filter
// Purpose  : N-tap moving-average (boxcar FIR) noise filter for signed audio
//            samples, one instance per channel. Each accepted sample is
//            pre-scaled by 1/N and a running sum of the last N scaled terms
//            is kept, so no divider is needed. Includes a bypass for A/B
//            listening.
// Ports    : clock      - system clock
//            reset      - asynchronous, active-low reset
//            in_valid   - sample strobe, one cycle per new sample
//            in_data    - incoming signed sample (DATA_W bits)
//            filter_en  - 1 = averaging, 0 = bypass
//            out_valid  - one-cycle pulse, out_data updated this cycle
//            out_data   - filtered (or bypassed) signed sample
// Options  : define AUDIO_AVG_ROUND_EN to round each scaled term half toward
//            +inf instead of truncating toward -inf.
// Revision : 1.0 - initial release
// ============================================================================
module audio_avg_filter #(
    parameter int DATA_W = 24,
    parameter int LOG2_N = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              filter_en,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);

    localparam int N     = 2**LOG2_N;
    localparam int ACC_W = DATA_W + 1;
    localparam int SUM_W = DATA_W + 2;

    logic signed [ACC_W-1:0]  in_ext;
    logic signed [ACC_W-1:0]  term;
    logic signed [ACC_W-1:0]  hist [N];
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  oldest;
    logic signed [SUM_W-1:0]  sum_next;
    logic signed [ACC_W-1:0]  acc_next;
    logic        [DATA_W-1:0] sat_out;
    logic        [LOG2_N:0]   fill_cnt;
    logic        [LOG2_N-1:0] wptr;
    logic                     full;

    assign in_ext = {in_data[DATA_W-1], in_data};

`ifdef AUDIO_AVG_ROUND_EN
    localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (LOG2_N - 1);
    logic signed [ACC_W-1:0] rounded;

    // One extra bit of headroom, so adding the half-LSB never overflows.
    assign rounded = in_ext + HALF;
    assign term    = rounded >>> LOG2_N;
`else
    assign term    = in_ext >>> LOG2_N;
`endif

    // fill_cnt saturates at exactly N = 2**LOG2_N, so its MSB marks "full".
    assign full     = fill_cnt[LOG2_N];
    assign oldest   = full ? hist[wptr] : '0;
    assign sum_next = SUM_W'(acc) + SUM_W'(term) - SUM_W'(oldest);
    assign acc_next = sum_next[ACC_W-1:0];

    // Clamp the DATA_W+1 bit sum into the DATA_W signed output range.
    always_comb begin
        sat_out = acc_next[DATA_W-1:0];
        if (acc_next[ACC_W-1] != acc_next[DATA_W-1]) begin
            if (acc_next[ACC_W-1]) begin
                sat_out = {1'b1, {(DATA_W-1){1'b0}}};
            end else begin
                sat_out = {1'b0, {(DATA_W-1){1'b1}}};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            acc       <= '0;
            fill_cnt  <= '0;
            wptr      <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                if (filter_en) begin
                    out_data <= sat_out;
                    acc      <= acc_next;
                    wptr     <= wptr + 1'b1;
                    if (!full) begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end else begin
                    // Bypass also restarts warm-up for the next enable.
                    out_data <= in_data;
                    acc      <= '0;
                    fill_cnt <= '0;
                    wptr     <= '0;
                end
            end
        end
    end

    // History is never read before it is rewritten after reset, so it
    // carries no reset.
    always_ff @(posedge clock) begin
        if (in_valid && filter_en) begin
            hist[wptr] <= term;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_audio_avg_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_audio_avg_filter
// Purpose  : Self-checking directed testbench for audio_avg_filter.
//            Expected values are hand-computed for 8 taps, 24-bit samples;
//            AUDIO_AVG_ROUND_EN selects the rounding expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_audio_avg_filter;

    logic        clock     = 1'b0;
    logic        reset     = 1'b0;
    logic        in_valid  = 1'b0;
    logic [23:0] in_data   = 24'h0;
    logic        filter_en = 1'b0;
    logic        out_valid;
    logic [23:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    audio_avg_filter #(
        .DATA_W (24),
        .LOG2_N (3)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .filter_en (filter_en),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    // One-cycle strobe; returns 1 time unit after the accepting edge.
    task automatic drive_one(input logic [23:0] d, input logic en);
        in_data   = d;
        filter_en = en;
        in_valid  = 1'b1;
        @(posedge clock);
        #1;
        in_valid  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        #12;
        n_checks++;
        if ({out_valid, out_data} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_low got v=%b d=%h expected v=0 d=000000", out_valid, out_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle(1);
        n_checks++;
        if ({out_valid, out_data} !== 25'h0) begin
            n_fail++;
            $display("FAIL reset_release got v=%b d=%h expected v=0 d=000000", out_valid, out_data);
        end
    endtask

    // Strobe every 4 cycles; ramp 0x100..0x800 then hold.
    task automatic test_warmup();
        logic [23:0] exp;
        for (int i = 1; i <= 11; i++) begin
            exp = (i < 8) ? 24'(i * 256) : 24'h000800;
            drive_one(24'h000800, 1'b1);
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL warmup[%0d] got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp);
            end
            idle(1);
            n_checks++;
            if ({out_valid, out_data} !== {1'b0, exp}) begin
                n_fail++;
                $display("FAIL warmup_gap[%0d] got v=%b d=%h expected v=0 d=%h", i, out_valid, out_data, exp);
            end
            idle(2);
        end
    endtask

    // Zeros after a full window of 0x800: oldest terms leave one by one.
    task automatic test_step_down();
        logic [23:0] exp;
        for (int i = 1; i <= 8; i++) begin
            exp = 24'h000800 - 24'(i * 256);
            drive_one(24'h000000, 1'b1);
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL step_down[%0d] got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp);
            end
            idle(1);
        end
    endtask

    task automatic test_small_values();
        logic [23:0] exp;
        drive_one(24'h000000, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            exp = 24'(-i);
            drive_one(24'hFFFFF8, 1'b1);
            n_checks++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL neg8[%0d] got %h expected %h", i, out_data, exp);
            end
        end
        drive_one(24'h000000, 1'b0);
        for (int i = 1; i <= 8; i++) begin
`ifdef AUDIO_AVG_ROUND_EN
            exp = 24'(i);
`else
            exp = 24'h000000;
`endif
            drive_one(24'h000007, 1'b1);
            n_checks++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL pos7[%0d] got %h expected %h", i, out_data, exp);
            end
        end
    endtask

    task automatic test_saturation();
        logic [23:0] exp;
        drive_one(24'h000000, 1'b0);
        for (int i = 1; i <= 10; i++) begin
`ifdef AUDIO_AVG_ROUND_EN
            exp = (i < 8) ? 24'(i * 24'h100000) : 24'h7FFFFF;
`else
            exp = 24'((i < 8 ? i : 8) * 24'h0FFFFF);
`endif
            drive_one(24'h7FFFFF, 1'b1);
            n_checks++;
            if (out_data !== exp) begin
                n_fail++;
                $display("FAIL max_pos[%0d] got %h expected %h", i, out_data, exp);
            end
        end
    endtask

    task automatic test_bypass();
        drive_one(24'h000000, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive_one(24'h000800, 1'b1);
        end
        n_checks++;
        if (out_data !== 24'h000800) begin
            n_fail++;
            $display("FAIL bypass_prefill got %h expected 000800", out_data);
        end
        for (int i = 0; i < 2; i++) begin
            drive_one(24'h123456, 1'b0);
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, 24'h123456}) begin
                n_fail++;
                $display("FAIL bypass[%0d] got v=%b d=%h expected v=1 d=123456", i, out_valid, out_data);
            end
        end
        // Enable without a strobe must not disturb the held output.
        filter_en = 1'b1;
        idle(3);
        n_checks++;
        if ({out_valid, out_data} !== {1'b0, 24'h123456}) begin
            n_fail++;
            $display("FAIL en_no_strobe got v=%b d=%h expected v=0 d=123456", out_valid, out_data);
        end
        drive_one(24'h000800, 1'b1);
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 24'h000100}) begin
            n_fail++;
            $display("FAIL reenable got v=%b d=%h expected v=1 d=000100", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] exp;
        drive_one(24'h000000, 1'b0);
        for (int i = 0; i < 4; i++) begin
            drive_one(24'h000800, 1'b1);
        end
        // Fifth sample: leave out_valid high, then reset between edges.
        drive_one(24'h000800, 1'b1);
        n_checks++;
        if ({out_valid, out_data} !== {1'b1, 24'h000500}) begin
            n_fail++;
            $display("FAIL pre_reset got v=%b d=%h expected v=1 d=000500", out_valid, out_data);
        end
        #2;
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, out_data} !== 25'h0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b d=%h expected v=0 d=000000", out_valid, out_data);
        end
        @(posedge clock);
        #1;
        reset = 1'b1;
        in_data   = 24'h000800;
        filter_en = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            exp = (i < 8) ? 24'(i * 256) : 24'h000800;
            @(posedge clock);
            #1;
            n_checks++;
            if ({out_valid, out_data} !== {1'b1, exp}) begin
                n_fail++;
                $display("FAIL full_rate[%0d] got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp);
            end
        end
        in_valid = 1'b0;
        @(posedge clock);
        #1;
        n_checks++;
        if ({out_valid, out_data} !== {1'b0, 24'h000800}) begin
            n_fail++;
            $display("FAIL full_rate_end got v=%b d=%h expected v=0 d=000800", out_valid, out_data);
        end
    endtask

    initial begin
        test_reset();
        test_warmup();
        test_step_down();
        test_small_values();
        test_saturation();
        test_bypass();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/audio_avg_filter.md
Name: audio_avg_filter

Overview:
- N-tap moving-average (boxcar FIR) noise filter for 24-bit signed audio samples.
- Sits directly downstream of the tone/passthrough mux, between the mux's left or right output and the codec write data. One instance per channel.
- Processes one sample per codec sample strobe.
- Selectable bypass for A/B listening.

Parameters:
DATA_W, 24, sample width (signed two's complement)
LOG2_N, 3, log2 of tap count; N = 2**LOG2_N (default 8 taps)

Ports:
clock  input  1  system clock (50 MHz)
reset  input  1  asynchronous, active-low reset
in_valid  input  1  sample strobe, one cycle per new sample (codec read_ready & write_ready)
in_data  input  DATA_W  incoming signed sample
filter_en  input  1  1 = averaging active, 0 = bypass
out_valid  output  1  one-cycle pulse, out_data updated this cycle
out_data  output  DATA_W  filtered (or bypassed) signed sample

Behaviour:
- Reset (reset low, asynchronous):
  - out_data=0, out_valid=0, accumulator=0, fill count=0, write pointer=0.
  - History buffer contents are don't-care; they are never read before being rewritten.
- Sample acceptance: a sample is taken only on a clock edge with in_valid=1. No back-pressure; the block accepts every strobe.
- Latency: out_valid asserts exactly 1 cycle after each accepted in_valid and is low otherwise.
- out_data holds its value between strobes.
- Scaling: term = in_data >>> LOG2_N (arithmetic shift, truncation toward -inf).
- History: circular buffer of N terms, write pointer wraps N-1 -> 0. Fill count saturates at N.
- Accumulator: signed, DATA_W+1 bits. On each accepted sample with filter_en=1:
  - Fill count < N: acc_next = acc + term; store term; count++.
  - Fill count == N: acc_next = acc + term - buffer[wptr]. The oldest term is read and overwritten in the same cycle.
- Output: out_data = acc_next saturated to the DATA_W signed range (0x7FFFFF / 0x800000).
- Warm-up: during the first N samples, output is the partial sum with no normalisation correction, so it ramps toward the steady value.
- Bypass: on an accepted sample with filter_en=0:
  - out_data = in_data, still with 1-cycle latency and out_valid pulse.
  - acc, fill count and wptr are cleared to 0, so re-enabling restarts warm-up.
- filter_en changing with no in_valid has no effect until the next strobe.
- in_valid held high on consecutive cycles: every cycle is a new sample. Full-rate operation is legal.

Optional Feature:
Macro: AUDIO_AVG_ROUND_EN
- Defined: term = (in_data + 2**(LOG2_N-1)) >>> LOG2_N, i.e. round half toward +inf.
  - The addition is done at DATA_W+1 bits, so there is no overflow.
  - The extra accumulator bit plus output saturation cover the max-positive case (8 × 0x100000 clamps to 0x7FFFFF).
- Undefined: plain truncating shift, as specified above.

Test Plan:
1. reset low then high; in_valid pulsed every 4 cycles with in_data=0x000800, filter_en=1 -> outputs 0x000100, 0x000200, …, 0x000800 on the 8th pulse. Output stays 0x000800 thereafter; out_valid exactly 1 cycle after each strobe.
2. Steady 0x000800 for 8 samples, then 0x000000 for 8 samples -> outputs step down by 0x100 per sample to 0x000000. Confirms oldest-term subtraction and pointer wrap.
3. Input 0xFFFFF8 (-8) for 8 samples -> term -1, final out_data=0xFFFFF8. Input 0x000007 ×8 -> out_data 0x000000 with macro undefined, 0x000008 with AUDIO_AVG_ROUND_EN.
4. Input 0x7FFFFF ×10, filter_en=1 -> out_data=0x7FFFF8 (truncate) or 0x7FFFFF (round, saturated). No wrap to negative.
5. After steady 0x000800, filter_en=0 for 2 samples of 0x123456 -> out_data=0x123456 each. Then filter_en=1 with 0x000800 -> output restarts at 0x000100.
6. Assert reset low mid-warm-up (after 5 samples) -> out_data=0 and out_valid=0 immediately, without waiting for a clock edge. After release, 0x000800 input restarts at 0x000100; back-to-back in_valid (every cycle) produces the same sequence at full rate.
